// File: rtl/irq_agg_pkg.sv
// irq_agg_pkg: shared register addresses, limits and helpers for the interrupt aggregator
package irq_agg_pkg;
  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE = 3'd1;
  localparam logic [2:0] ADDR_MODE = 3'd2;
  localparam logic [2:0] ADDR_VECTOR = 3'd3;
  localparam logic [2:0] ADDR_RAW = 3'd4;
  localparam logic [2:0] ADDR_FORCE = 3'd5;
  localparam int VECTOR_VALID_BIT = 15;
  localparam int MAX_SRC = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder returning the lowest set request index
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);
  assign valid = |req;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? 4'(i) : idx;
  end
endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: Avalon-MM interrupt controller with per-source pending, enable, edge/level mode and priority vector
module irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_SRC-1:0] irq_in,
  output logic             irq
);
  localparam int IW = clog2(MAX_SRC);
  logic [N_SRC-1:0] pending, enable, mode, irq_d, rise, clr, force_set, pend_nxt, act;
  logic wr, valid;
  logic [IW-1:0] idx;
  logic [15:0] vector, rd;
  assign wr = chipselect & ~write_n;
  assign clr = (wr && address == ADDR_PENDING) ? writedata[N_SRC-1:0] : '0;
  assign force_set = (wr && address == ADDR_FORCE) ? writedata[N_SRC-1:0] : '0;
  assign rise = irq_in & ~irq_d;
  assign pend_nxt = (mode & (rise | force_set | (pending & ~clr))) | (~mode & irq_in);
  assign act = pending & enable;
  irq_prio_enc #(.N(N_SRC)) u_enc (.req(act), .valid(valid), .idx(idx));
  always_comb begin
    vector = '0;
    vector[VECTOR_VALID_BIT] = valid;
    vector[IW-1:0] = idx;
  end
  always_comb begin
    rd = address == ADDR_PENDING ? 16'(pending) :
         address == ADDR_ENABLE  ? 16'(enable)  :
         address == ADDR_MODE    ? 16'(mode)    :
         address == ADDR_VECTOR  ? vector       :
         address == ADDR_RAW     ? 16'(irq_in)  : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      enable <= '0;
      mode <= '0;
      irq_d <= '0;
      readdata <= '0;
      irq <= 1'b0;
    end else begin
      pending <= pend_nxt;
      irq_d <= irq_in;
      readdata <= rd;
      irq <= |act;
      if (wr && address == ADDR_ENABLE) enable <= writedata[N_SRC-1:0];
      if (wr && address == ADDR_MODE) mode <= writedata[N_SRC-1:0];
    end
  end
endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: directed self-checking bench with a read scoreboard for irq_aggregator
module tb_irq_aggregator;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1, irq;
  logic [2:0] address = '0;
  logic [15:0] writedata = '0, readdata;
  logic [7:0] irq_in = '0;
  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  string tag_q[$];
  irq_aggregator #(.N_SRC(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    address = a;
    chipselect = 1;
    write_n = 1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    chipselect = 0;
    chk(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    tick();
    chipselect = 0;
    write_n = 1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_readdata", readdata, 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    reset = 0;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0, $sformatf("rst_read_a%0d", a));
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    chk("edge_irq_lat1", 16'(irq), 16'h0);
    rd(3'd0, 16'h0001, "edge_pending");
    chk("edge_irq_lat2", 16'(irq), 16'h1);
    rd(3'd3, 16'h8000, "edge_vector0");
    wr(3'd0, 16'h0001);
    chk("w1c_irq_still", 16'(irq), 16'h1);
    rd(3'd0, 16'h0000, "w1c_pending");
    chk("w1c_irq_low", 16'(irq), 16'h0);
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0004);
    irq_in = 8'h04;
    tick();
    rd(3'd0, 16'h0004, "level_pending");
    chk("level_irq", 16'(irq), 16'h1);
    rd(3'd3, 16'h8002, "level_vector2");
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0004, "level_w1c_noeffect");
    irq_in = 8'h00;
    tick();
    chk("level_drop_irq_hold", 16'(irq), 16'h1);
    tick();
    chk("level_drop_irq_low", 16'(irq), 16'h0);
    rd(3'd0, 16'h0000, "level_drop_pending");
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'hFFFF);
    rd(3'd1, 16'h00FF, "enable_upper_bits");
    rd(3'd2, 16'h00FF, "mode_readback");
    irq_in = 8'h28;
    tick();
    rd(3'd4, 16'h0028, "raw");
    rd(3'd3, 16'h8003, "prio_vector3");
    wr(3'd0, 16'h0008);
    rd(3'd3, 16'h8005, "prio_vector5");
    wr(3'd0, 16'h0020);
    rd(3'd3, 16'h0000, "prio_vector_none");
    chk("prio_irq_low", 16'(irq), 16'h0);
    irq_in = 8'h00;
    tick();
    wr(3'd2, 16'h0002);
    tick();
    irq_in = 8'h02;
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0002, "set_beats_clear");
    irq_in = 8'h00;
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0000, "clear_bit1");
    wr(3'd5, 16'h0002);
    rd(3'd0, 16'h0002, "force_edge");
    rd(3'd5, 16'h0000, "force_reads0");
    wr(3'd0, 16'h0002);
    wr(3'd5, 16'h0001);
    rd(3'd0, 16'h0000, "force_level_noeffect");
    irq_in = 8'h01;
    reset = 1;
    tick();
    tick();
    chk("rst2_readdata", readdata, 16'h0);
    chk("rst2_irq", 16'(irq), 16'h0);
    reset = 0;
    wr(3'd2, 16'h0001);
    rd(3'd0, 16'h0001, "held_through_reset");
    chk("disabled_irq", 16'(irq), 16'h0);
    tick();
    chk("disabled_irq_stays", 16'(irq), 16'h0);
    rd(3'd3, 16'h0000, "disabled_vector");
    wr(3'd0, 16'h0001);
    rd(3'd0, 16'h0000, "held_edge_cleared");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
